prio_arbiter: RTL and testbench

PRIO_ARBITER -- requirements
Module: prio_arbiter

---
 rtl/prio_arbiter.sv | 142 ++++++++++++++
 tb/tb_prio_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/prio_arbiter.sv
// prio_arbiter: N = 2**n requester arbiter with fixed-priority and round-robin
// selection, a bounded hold time per grant and a mandatory idle cycle between
// grants. All outputs are registered.
module prio_arbiter #(
  parameter int n        = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [(1<<n)-1:0] req,
  input  logic              mode,
  input  logic              done,
  output logic [(1<<n)-1:0] gnt,
  output logic [n-1:0]      gnt_id,
  output logic              gnt_valid,
  output logic              timeout
);

  localparam int N = 1 << n;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [n-1:0]  gnt_id_q, gnt_id_d;
  logic          gnt_valid_q, gnt_valid_d;
  logic          timeout_q, timeout_d;
  logic [15:0]   hold_q, hold_d;
  logic [n-1:0]  last_id_q, last_id_d;

  logic [n-1:0]  search_start_s;
  logic [n-1:0]  search_idx_s;
  logic [n-1:0]  win_id_s;
  logic          win_found_s;
  logic          hold_max_s;
  logic          holder_req_s;
  logic          release_s;

  // Winner search: descending scan with wrap. Fixed mode starts at N-1,
  // round-robin starts just below the most recent grant.
  always_comb begin
    win_id_s       = {n{1'b0}};
    win_found_s    = 1'b0;
    search_idx_s   = {n{1'b0}};
    if (mode == 1'b1) begin
      search_start_s = last_id_q - n'(1);
    end else begin
      search_start_s = n'(N - 1);
    end
    for (int i = 0; i < N; i++) begin
      search_idx_s = search_start_s - n'(i);
      if (!win_found_s && req[search_idx_s]) begin
        win_id_s    = search_idx_s;
        win_found_s = 1'b1;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state and registered-output computation for the IDLE/GRANT FSM.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    gnt_id_d     = gnt_id_q;
    gnt_valid_d  = gnt_valid_q;
    timeout_d    = 1'b0;
    hold_d       = hold_q;
    last_id_d    = last_id_q;
    hold_max_s   = (hold_q == 16'(MAX_HOLD));
    holder_req_s = req[gnt_id_q];
    release_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found_s) begin
          state_d     = GRANT;
          gnt_d       = {{(N-1){1'b0}}, 1'b1} << win_id_s;
          gnt_id_d    = win_id_s;
          gnt_valid_d = 1'b1;
          hold_d      = 16'd1;
          last_id_d   = win_id_s;
        end else begin
          gnt_d       = {N{1'b0}};
          gnt_id_d    = {n{1'b0}};
          gnt_valid_d = 1'b0;
          hold_d      = 16'd0;
        end
      end
      GRANT: begin
        release_s = done | ~holder_req_s | hold_max_s;
        if (release_s) begin
          state_d     = IDLE;
          gnt_d       = {N{1'b0}};
          gnt_id_d    = {n{1'b0}};
          gnt_valid_d = 1'b0;
          hold_d      = 16'd0;
          // A coincident done or request drop wins over the timeout.
          timeout_d   = hold_max_s & ~done & holder_req_s;
        end else begin
          hold_d      = hold_q + 16'd1;
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = {N{1'b0}};
        gnt_id_d    = {n{1'b0}};
        gnt_valid_d = 1'b0;
        hold_d      = 16'd0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= {N{1'b0}};
      gnt_id_q    <= {n{1'b0}};
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      hold_q      <= 16'd0;
      last_id_q   <= {n{1'b0}};
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      hold_q      <= hold_d;
      last_id_q   <= last_id_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_prio_arbiter.sv
// tb_prio_arbiter: directed, self-checking bench for prio_arbiter (n=3, MAX_HOLD=4).
module tb_prio_arbiter;

  localparam int n  = 3;
  localparam int N  = 8;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mode;
  logic         done;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [n-1:0] gnt_id;
  logic         gnt_valid;
  logic         timeout;

  int total = 0;
  int bad   = 0;
  int rr_seq [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};

  prio_arbiter #(.n(n), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mode      (mode),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare {gnt, gnt_id, gnt_valid, timeout} against the expected tuple.
  task automatic expect_out(input string tag, input logic v, input int id, input logic to);
    logic [N+n+1:0] exp_v;
    logic [N+n+1:0] obs_v;
    logic [N-1:0]   g;
    logic [n-1:0]   id_e;
    id_e  = v ? n'(id) : {n{1'b0}};
    g     = v ? ({{(N-1){1'b0}}, 1'b1} << id_e) : {N{1'b0}};
    exp_v = {g, id_e, v, to};
    obs_v = {gnt, gnt_id, gnt_valid, timeout};
    total++;
    assert (obs_v === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs_v, exp_v);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    mode  = 1'b0;
    done  = 1'b0;
    step();
    step();
    expect_out("reset", 1'b0, 0, 1'b0);
    rst_n = 1'b1;
    step();
    expect_out("idle_noreq", 1'b0, 0, 1'b0);

    // Fixed priority with req = 0010_0110: always 5, one idle cycle between.
    req = 8'b0010_0110;
    step();
    expect_out("fix_g1", 1'b1, 5, 1'b0);
    done = 1'b1;
    step();
    expect_out("fix_rel1", 1'b0, 0, 1'b0);
    done = 1'b0;
    step();
    expect_out("fix_g2", 1'b1, 5, 1'b0);
    done = 1'b1;
    step();
    expect_out("fix_rel2", 1'b0, 0, 1'b0);
    done = 1'b0;
    step();
    expect_out("fix_g3", 1'b1, 5, 1'b0);
    done = 1'b1;
    req  = 8'h00;
    step();
    expect_out("fix_rel3", 1'b0, 0, 1'b0);
    done = 1'b0;

    // Round-robin from a fresh reset: 7,6,...,0,7.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    mode  = 1'b1;
    req   = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      step();
      expect_out($sformatf("rr_g%0d", k), 1'b1, rr_seq[k], 1'b0);
      done = 1'b1;
      step();
      expect_out($sformatf("rr_rel%0d", k), 1'b0, 0, 1'b0);
      done = 1'b0;
    end
    req = 8'h00;
    step();
    expect_out("rr_idle", 1'b0, 0, 1'b0);

    // Timeout: req = 01 held, done low, MAX_HOLD = 4.
    mode = 1'b0;
    req  = 8'h01;
    for (int k = 0; k < MH; k++) begin
      step();
      expect_out($sformatf("to_hold%0d", k), 1'b1, 0, 1'b0);
    end
    step();
    expect_out("to_pulse", 1'b0, 0, 1'b1);
    step();
    expect_out("to_regrant", 1'b1, 0, 1'b0);
    step();
    step();
    step();
    expect_out("to_cnt4", 1'b1, 0, 1'b0);
    done = 1'b1;
    step();
    expect_out("to_coincide", 1'b0, 0, 1'b0);
    done = 1'b0;
    req  = 8'h00;
    step();
    expect_out("to_idle", 1'b0, 0, 1'b0);

    // Holder drops its request while requester 6 waits; no pre-emption before.
    req = 8'h08;
    step();
    expect_out("drop_g3", 1'b1, 3, 1'b0);
    req = 8'h48;
    step();
    expect_out("no_preempt", 1'b1, 3, 1'b0);
    req = 8'h40;
    step();
    expect_out("drop_rel", 1'b0, 0, 1'b0);
    step();
    expect_out("drop_g6", 1'b1, 6, 1'b0);
    req = 8'h00;
    step();
    expect_out("drop_idle", 1'b0, 0, 1'b0);

    // Mode toggling during GRANT, then done in IDLE.
    req = 8'h12;
    step();
    expect_out("mode_g4", 1'b1, 4, 1'b0);
    mode = 1'b1;
    step();
    expect_out("mode_hold1", 1'b1, 4, 1'b0);
    mode = 1'b0;
    step();
    expect_out("mode_hold2", 1'b1, 4, 1'b0);
    done = 1'b1;
    req  = 8'h00;
    step();
    expect_out("mode_rel", 1'b0, 0, 1'b0);
    step();
    expect_out("done_idle1", 1'b0, 0, 1'b0);
    step();
    expect_out("done_idle2", 1'b0, 0, 1'b0);
    done = 1'b0;
    mode = 1'b1;
    req  = 8'h12;
    step();
    expect_out("rr_after4", 1'b1, 1, 1'b0);
    req = 8'h00;
    step();
    expect_out("rr_after4_rel", 1'b0, 0, 1'b0);

    // Asynchronous reset mid-GRANT, then round-robin restarts at 7.
    mode = 1'b0;
    req  = 8'h80;
    step();
    expect_out("async_g7", 1'b1, 7, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    expect_out("async_clear", 1'b0, 0, 1'b0);
    step();
    expect_out("async_held", 1'b0, 0, 1'b0);
    rst_n = 1'b1;
    mode  = 1'b1;
    req   = 8'hFF;
    step();
    expect_out("post_rst_g7", 1'b1, 7, 1'b0);
    done = 1'b1;
    step();
    expect_out("post_rst_rel", 1'b0, 0, 1'b0);
    done = 1'b0;
    req  = 8'h00;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
